// File: rtl/mem_model_pkg.sv
// Shared widths, FSM state encoding and line type for the burst memory responder.
package mem_model_pkg;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} burst_state_t;
    typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/burst_mem_responder_if.sv
// Cacheline-adaptor burst bus: 32-bit line address, read/write request, 64-bit beats.
interface burst_mem_responder_if;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;

    modport master (output address_i, read_i, write_i, burst_i, input burst_o, resp_o);
    modport slave  (input address_i, read_i, write_i, burst_i, output burst_o, resp_o);
endinterface

// File: rtl/burst_line_ram.sv
// Line store: 2**IDX_BITS lines of 256b, 64-bit lane write, async 64-bit beat read.
module burst_line_ram
    import mem_model_pkg::*;
#(
    parameter int IDX_BITS = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] idx,
    input  logic [1:0]          wbeat,
    input  logic [BEAT_W-1:0]   wdata,
    input  logic [1:0]          rbeat,
    output logic [BEAT_W-1:0]   rdata
);
    line_t mem [2**IDX_BITS];

    // Contents survive reset so partial writes remain visible afterwards.
    always_ff @(posedge clk) begin
        if (we) mem[idx][wbeat*BEAT_W +: BEAT_W] <= wdata;
    end

    assign rdata = mem[idx][rbeat*BEAT_W +: BEAT_W];
endmodule

// File: rtl/burst_mem_responder.sv
// Fixed-latency 4-beat burst responder backed by burst_line_ram.
// Optional MEM_ERR_CHECK_EN adds the sticky protocol-violation output err_o.
module burst_mem_responder
    import mem_model_pkg::*;
#(
    parameter int LATENCY       = 4,
    parameter int LINE_IDX_BITS = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    burst_mem_responder_if.slave        bus
`ifdef MEM_ERR_CHECK_EN
    ,
    output logic                        err_o
`endif
);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    burst_state_t             state, nxt;
    logic [3:0]               lat_cnt;
    logic [1:0]               beat;
    logic [LINE_IDX_BITS-1:0] idx;
    logic                     op_rd;
    logic                     req;
    logic                     we;
    logic [BEAT_W-1:0]        rdata;

    assign req = bus.read_i | bus.write_i;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = WAIT;
            WAIT:    if (!req) nxt = IDLE;
                     else if (lat_cnt == 4'd0) nxt = BURST;
            BURST:   if (!req) nxt = IDLE;
                     else if (beat == 2'd3) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
            beat    <= 2'd0;
            idx     <= '0;
            op_rd   <= 1'b0;
        end else begin
            state <= nxt;
            // read_i takes priority when both requests are raised together
            if (state == IDLE && req) begin
                idx     <= bus.address_i[LINE_IDX_BITS+4:5];
                op_rd   <= bus.read_i;
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            beat <= (state == BURST && nxt == BURST) ? beat + 2'd1 : 2'd0;
        end
    end

    assign bus.resp_o  = (state == BURST);
    // A beat seen while the request is already dropped is not committed.
    assign we          = bus.resp_o & ~op_rd & req;
    assign bus.burst_o = (bus.resp_o && op_rd) ? rdata : '0;

    burst_line_ram #(.IDX_BITS(LINE_IDX_BITS)) u_ram (
        .clk   (clk),
        .we    (we),
        .idx   (idx),
        .wbeat (beat),
        .wdata (bus.burst_i),
        .rbeat (beat),
        .rdata (rdata)
    );

    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.address_i[4:0];

`ifdef MEM_ERR_CHECK_EN
    logic [26:0] cap_tag;
    logic        busy;
    logic        viol;

    assign busy = (state == WAIT) || (state == BURST);
    assign viol = (bus.read_i & bus.write_i) |
                  (busy & (!req || bus.address_i[31:5] != cap_tag ||
                           bus.read_i != op_rd));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_tag <= '0;
            err_o   <= 1'b0;
        end else begin
            if (state == IDLE && req) cap_tag <= bus.address_i[31:5];
            if (viol) err_o <= 1'b1;
        end
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address_i[31:LINE_IDX_BITS+5];
`endif
endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized check of burst_mem_responder against a line-array reference model.
module tb_burst_mem_responder;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    bit   in_done = 1'b0;

    logic [63:0] mdl   [256][4];
    bit          known [256][4];

    burst_mem_responder_if ifc ();
`ifdef MEM_ERR_CHECK_EN
    logic err_o;
`endif

    burst_mem_responder #(.LATENCY(LAT), .LINE_IDX_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
`ifdef MEM_ERR_CHECK_EN
        ,
        .err_o   (err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; drop_at<4 releases the request during that beat's cycle.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                       input int drop_at, input logic [63:0] d0);
        int n;
        int exp_n;
        logic [7:0] li;
        bit is_rd;
        li    = addr[12:5];
        is_rd = rd;
        exp_n = in_done ? LAT + 2 : LAT + 1;
        ifc.address_i = addr;
        ifc.read_i    = rd;
        ifc.write_i   = wr;
        ifc.burst_i   = d0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ifc.resp_o && n < 40);
        chk("latency", 64'(n), 64'(exp_n));
        if (!ifc.resp_o) begin
            ifc.read_i = 0; ifc.write_i = 0; in_done = 0;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            chk("resp_hi", 64'(ifc.resp_o), 64'd1);
            if (is_rd && known[li][b]) chk("rdata", ifc.burst_o, mdl[li][b]);
            if (b == drop_at) begin
                ifc.read_i = 0; ifc.write_i = 0;
                @(posedge clk); #1;
                chk("resp_drop", 64'(ifc.resp_o), 64'd0);
                in_done = 0;
                return;
            end
            @(posedge clk);
            if (!is_rd) begin
                mdl[li][b]   = d0 + 64'(b);
                known[li][b] = 1'b1;
            end
            #1;
            ifc.burst_i = d0 + 64'(b + 1);
        end
        chk("resp_done", 64'(ifc.resp_o), 64'd0);
        chk("bo_done", ifc.burst_o, 64'd0);
        ifc.read_i = 0; ifc.write_i = 0;
        in_done = 1;
    endtask

    task automatic idle(input int g);
        repeat (g) begin @(posedge clk); #1; end
        if (g > 0) in_done = 0;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) for (int j = 0; j < 4; j++) known[i][j] = 0;
        reset_n = 0;
        ifc.address_i = 0; ifc.read_i = 0; ifc.write_i = 0; ifc.burst_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", 64'(ifc.resp_o), 64'd0);
        chk("rst_bo", ifc.burst_o, 64'd0);
`ifdef MEM_ERR_CHECK_EN
        chk("rst_err", 64'(err_o), 64'd0);
`endif
        reset_n = 1;
        idle(2);

        // write idx 3 then read back
        txn(0, 1, 32'h0000_0060, 4, 64'h0123_4567_89AB_CDEF);
        idle(1);
        txn(1, 0, 32'h0000_0060, 4, 0);
        // write idx 4, then back-to-back read of unwritten idx 5
        idle(2);
        txn(0, 1, 32'h0000_0080, 4, 64'hCAFE_0000_0000_0040);
        txn(1, 0, 32'h0000_00A0, 4, 0);
        // aliasing address with low bits set
        idle(1);
        txn(0, 1, 32'h0000_207F, 4, 64'h5555_AAAA_0000_1000);
        txn(1, 0, 32'h0000_0060, 4, 0);
        // partial write to idx 3, then read back mixed contents
        idle(1);
        txn(0, 1, 32'h0000_0060, 2, 64'hB0B0_B0B0_0000_0000);
        txn(1, 0, 32'h0000_0060, 4, 0);

        for (int k = 0; k < 30; k++) begin
            bit rd;
            int dr;
            rd = ($urandom_range(0, 1) == 1);
            a  = $urandom;
            a[12:5] = 8'($urandom_range(0, 11));
            dr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 4;
            idle($urandom_range(0, 2));
            txn(rd, !rd, a, dr, {$urandom, $urandom});
        end

        // both requests high: read wins, store unchanged
        idle(1);
        txn(1, 1, 32'h0000_0060, 4, 64'hDEAD_BEEF_DEAD_BEEF);
        txn(1, 0, 32'h0000_0060, 4, 0);
`ifdef MEM_ERR_CHECK_EN
        chk("err_set", 64'(err_o), 64'd1);
        idle(3);
        chk("err_sticky", 64'(err_o), 64'd1);
`endif

        // async reset in the middle of a read burst
        idle(1);
        ifc.address_i = 32'h0000_0060; ifc.read_i = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ifc.resp_o && n < 40);
        chk("mid_resp", 64'(ifc.resp_o), 64'd1);
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        chk("arst_resp", 64'(ifc.resp_o), 64'd0);
        chk("arst_bo", ifc.burst_o, 64'd0);
`ifdef MEM_ERR_CHECK_EN
        chk("arst_err", 64'(err_o), 64'd0);
`endif
        ifc.read_i = 0;
        @(posedge clk); #1;
        reset_n = 1;
        in_done = 0;
        idle(1);
        txn(1, 0, 32'h0000_0060, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
